axi_lite_regfile: RTL

Parametrised AXI4-Lite slave register file: NUM_REGS registers of DATA_WIDTH bits at a configurable base address.
- Write and read channels run as independent FSMs.
- Supports byte-strobed writes and AW/W arriving in either order.
- A per-register read-only mask lets selected registers return live status inputs.
- Returns SLVERR for out-of-range or read-only writes.
- Sits between the interconnect and user logic as the standard control/status block.

---
 rtl/axi_lite_pkg.sv | 27 ++
 rtl/axi_lite_addr_decode.sv | 27 ++
 rtl/axi_lite_regfile.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types, response codes and helpers for the AXI4-Lite register file.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = 32'(i) + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Maps a byte address onto a register index and flags whether it hits the register window.
module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
    localparam int unsigned           IDX_WIDTH  = clog2(NUM_REGS)
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [IDX_WIDTH-1:0]  o_idx_c,
    output logic                  o_in_range_c
);

    localparam int unsigned           BYTES = DATA_WIDTH / 8;
    localparam int unsigned           BL    = clog2(BYTES);
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(NUM_REGS * BYTES);

    logic [ADDR_WIDTH-1:0] w_off;

    // Addresses below the base wrap to a large offset and so fall out of range.
    assign w_off        = i_addr - BASE_ADDR;
    assign o_idx_c      = w_off[IDX_WIDTH+BL-1:BL];
    assign o_in_range_c = (w_off < SPAN);

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file with independent write/read FSMs, byte strobes,
// read-only status registers and per-register commit strobes.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int unsigned                     ADDR_WIDTH = 32,
    parameter int unsigned                     DATA_WIDTH = 32,
    parameter int unsigned                     NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0]           BASE_ADDR  = '0,
    parameter logic [NUM_REGS-1:0]             RO_MASK    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VAL  = '0
) (
    input  logic                           axi_lite_aclk,
    input  logic                           axi_lite_areset,
    input  logic [ADDR_WIDTH-1:0]          axi_lite_awaddr,
    input  logic                           axi_lite_awvalid,
    output logic                           axi_lite_awready,
    input  logic [DATA_WIDTH-1:0]          axi_lite_wdata,
    input  logic [DATA_WIDTH/8-1:0]        axi_lite_wstrb,
    input  logic                           axi_lite_wvalid,
    output logic                           axi_lite_wready,
    output logic [1:0]                     axi_lite_bresp,
    output logic                           axi_lite_bvalid,
    input  logic                           axi_lite_bready,
    input  logic [ADDR_WIDTH-1:0]          axi_lite_araddr,
    input  logic                           axi_lite_arvalid,
    output logic                           axi_lite_arready,
    output logic [DATA_WIDTH-1:0]          axi_lite_rdata,
    output logic [1:0]                     axi_lite_rresp,
    output logic                           axi_lite_rvalid,
    input  logic                           axi_lite_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH  = clog2(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_status;

    wr_state_e             r_wstate, w_wstate_nxt;
    logic                  r_aw_held, w_aw_held_nxt;
    logic                  r_w_held, w_w_held_nxt;
    logic                  r_awready, w_awready_nxt;
    logic                  r_wready, w_wready_nxt;
    logic                  r_bvalid, w_bvalid_nxt;
    logic [1:0]            r_bresp, w_bresp_nxt;
    logic [NUM_REGS-1:0]   r_wr_pulse, w_wr_pulse_nxt;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  w_commit;

    rd_state_e             r_rstate, w_rstate_nxt;
    logic                  r_arready, w_arready_nxt;
    logic                  r_rvalid, w_rvalid_nxt;
    logic [1:0]            r_rresp, w_rresp_nxt;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;

    logic [IDX_WIDTH-1:0]  w_wr_idx, w_rd_idx;
    logic                  w_wr_in_range, w_rd_in_range;
    logic                  w_wr_ok;

    assign w_status = status_in;
    assign ctrl_out = r_regs;

    axi_lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_wr_dec (
        .i_addr       (r_awaddr),
        .o_idx_c      (w_wr_idx),
        .o_in_range_c (w_wr_in_range)
    );

    axi_lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_rd_dec (
        .i_addr       (axi_lite_araddr),
        .o_idx_c      (w_rd_idx),
        .o_in_range_c (w_rd_in_range)
    );

    assign w_wr_ok = w_wr_in_range && !RO_MASK[w_wr_idx];

    // Write FSM next-state: commits once both address and data are held.
    always_comb begin
        w_wstate_nxt   = r_wstate;
        w_aw_held_nxt  = r_aw_held;
        w_w_held_nxt   = r_w_held;
        w_bvalid_nxt   = r_bvalid;
        w_bresp_nxt    = r_bresp;
        w_wr_pulse_nxt = '0;
        w_commit       = 1'b0;
        unique case (r_wstate)
            W_IDLE: begin
                if (axi_lite_awvalid && r_awready) w_aw_held_nxt = 1'b1;
                if (axi_lite_wvalid && r_wready)   w_w_held_nxt  = 1'b1;
                if (r_aw_held && r_w_held) begin
                    w_wstate_nxt = W_RESP;
                    w_bvalid_nxt = 1'b1;
                    if (w_wr_ok) begin
                        w_commit                 = 1'b1;
                        w_bresp_nxt              = RESP_OKAY;
                        w_wr_pulse_nxt[w_wr_idx] = 1'b1;
                    end else begin
                        w_bresp_nxt = RESP_SLVERR;
                    end
                end
            end
            W_RESP: begin
                if (axi_lite_bready) begin
                    w_wstate_nxt  = W_IDLE;
                    w_bvalid_nxt  = 1'b0;
                    w_aw_held_nxt = 1'b0;
                    w_w_held_nxt  = 1'b0;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
        w_awready_nxt = (w_wstate_nxt == W_IDLE) && !w_aw_held_nxt;
        w_wready_nxt  = (w_wstate_nxt == W_IDLE) && !w_w_held_nxt;
    end

    always_ff @(posedge axi_lite_aclk or posedge axi_lite_areset) begin
        if (axi_lite_areset) begin
            r_wstate   <= W_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wstate   <= w_wstate_nxt;
            r_aw_held  <= w_aw_held_nxt;
            r_w_held   <= w_w_held_nxt;
            r_awready  <= w_awready_nxt;
            r_wready   <= w_wready_nxt;
            r_bvalid   <= w_bvalid_nxt;
            r_bresp    <= w_bresp_nxt;
            r_wr_pulse <= w_wr_pulse_nxt;
        end
    end

    // Write address/data capture on their handshakes.
    always_ff @(posedge axi_lite_aclk or posedge axi_lite_areset) begin
        if (axi_lite_areset) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else begin
            if (axi_lite_awvalid && r_awready) r_awaddr <= axi_lite_awaddr;
            if (axi_lite_wvalid && r_wready) begin
                r_wdata <= axi_lite_wdata;
                r_wstrb <= axi_lite_wstrb;
            end
        end
    end

    // Register storage with byte-strobed update.
    always_ff @(posedge axi_lite_aclk or posedge axi_lite_areset) begin
        if (axi_lite_areset) begin
            r_regs <= RESET_VAL;
        end else if (w_commit) begin
            for (int b = 0; b < int'(STRB_WIDTH); b++) begin
                if (r_wstrb[b]) r_regs[w_wr_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
            end
        end
    end

    // Read FSM next-state: data is sampled at the AR handshake edge.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rvalid_nxt = r_rvalid;
        w_rresp_nxt  = r_rresp;
        w_rdata_nxt  = r_rdata;
        unique case (r_rstate)
            R_IDLE: begin
                if (axi_lite_arvalid && r_arready) begin
                    w_rstate_nxt = R_DATA;
                    w_rvalid_nxt = 1'b1;
                    if (w_rd_in_range) begin
                        w_rdata_nxt = RO_MASK[w_rd_idx] ? w_status[w_rd_idx] : r_regs[w_rd_idx];
                        w_rresp_nxt = RESP_OKAY;
                    end else begin
                        w_rdata_nxt = '0;
                        w_rresp_nxt = RESP_SLVERR;
                    end
                end
            end
            R_DATA: begin
                if (axi_lite_rready) begin
                    w_rstate_nxt = R_IDLE;
                    w_rvalid_nxt = 1'b0;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
        w_arready_nxt = (w_rstate_nxt == R_IDLE);
    end

    always_ff @(posedge axi_lite_aclk or posedge axi_lite_areset) begin
        if (axi_lite_areset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rresp   <= w_rresp_nxt;
            r_rdata   <= w_rdata_nxt;
        end
    end

    assign axi_lite_awready = r_awready;
    assign axi_lite_wready  = r_wready;
    assign axi_lite_bvalid  = r_bvalid;
    assign axi_lite_bresp   = r_bresp;
    assign axi_lite_arready = r_arready;
    assign axi_lite_rvalid  = r_rvalid;
    assign axi_lite_rresp   = r_rresp;
    assign axi_lite_rdata   = r_rdata;
    assign wr_pulse         = r_wr_pulse;

endmodule
